// File: rtl/sram_mem_ctrl_pkg.sv
// sram_mem_ctrl_pkg: FSM state encoding and default data-memory base address
package sram_mem_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;
    localparam int BASE_ADDR_DEF = 1024;
endpackage

// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl: maps 32-bit loads/stores onto two 16-bit SRAM half-accesses, freezing the pipeline meanwhile
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 1,
    parameter int BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r_en,
    input  logic               mem_w_en,
    input  logic [31:0]        addr,
    input  logic [31:0]        st_val,
    output logic [31:0]        rd_data,
    output logic               ready,
    output logic               freeze,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);
    localparam int CW = $clog2(WAIT_CYCLES + 1);
    localparam logic [CW-1:0] CMAX = CW'(WAIT_CYCLES);

    state_t      state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic        op_w, op_nxt, req, last, idle, phase_nxt;
    logic [31:0] word, word_nxt, st_q, st_nxt, hw;
    logic [15:0] lo_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        req       = mem_r_en | mem_w_en;
        idle      = state == IDLE;
        last      = cnt == CMAX;
        state_nxt = idle ? (req ? LO : IDLE) :
                    state == LO ? (last ? HI : LO) :
                    state == HI ? (last ? DONE : HI) : IDLE;
        cnt_nxt   = (state == LO || state == HI) && !last ? cnt + CW'(1) : '0;
        op_nxt    = idle ? mem_w_en : op_w;
        word_nxt  = idle ? (addr - 32'(BASE_ADDR)) >> 2 : word;
        st_nxt    = idle ? st_val : st_q;
        phase_nxt = state_nxt == LO || state_nxt == HI;
        hw        = {word_nxt[30:0], state_nxt == HI};
    end

    always_comb begin
        freeze = rst && ((idle && req) || state == LO || state == HI);
        ready  = state == DONE;
    end

    // SRAM strobes are set up one edge ahead so they are clean registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_w        <= 1'b0;
            word        <= '0;
            st_q        <= '0;
            lo_q        <= '0;
            rd_data     <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
        end else begin
            op_w <= op_nxt;
            word <= word_nxt;
            st_q <= st_nxt;
            if (phase_nxt) begin
                sram_addr   <= hw[SRAM_AW-1:0];
                sram_dq_out <= state_nxt == HI ? st_nxt[31:16] : st_nxt[15:0];
                sram_dq_oe  <= op_nxt;
                sram_oe_n   <= op_nxt;
                sram_we_n   <= !(op_nxt && cnt_nxt != CMAX);
            end else begin
                sram_dq_oe <= 1'b0;
                sram_we_n  <= 1'b1;
                sram_oe_n  <= 1'b1;
            end
            if (state == LO && last && !op_w)
                lo_q <= sram_dq_in;
            if (state == HI && last && !op_w)
                rd_data <= {sram_dq_in, lo_q};
        end
    end
endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb_sram_mem_ctrl: directed bench with an SRAM model and an expected-result scoreboard
module tb_sram_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_r_en = 1'b0, mem_w_en = 1'b0;
    logic [31:0] addr = '0, st_val = '0;
    logic [31:0] rd_data;
    logic        ready, freeze;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    int errors = 0;
    int checks = 0;

    logic [15:0] smem [0:63];
    logic        pend = 1'b0;
    logic [5:0]  paddr = '0;
    logic [15:0] pdata = '0;

    logic [31:0] exp_q [$];
    logic [31:0] ref_mem [int];
    logic [31:0] last_rd = '0;

    sram_mem_ctrl dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .addr(addr), .st_val(st_val), .rd_data(rd_data), .ready(ready),
        .freeze(freeze), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    always #5 clk = ~clk;

    // Write lands only when the strobe is released while data is still driven
    assign sram_dq_in = !sram_oe_n ? smem[sram_addr[5:0]] : 16'h0000;
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            pend  <= 1'b1;
            paddr <= sram_addr[5:0];
            pdata <= sram_dq_out;
        end else begin
            if (pend && sram_we_n && sram_dq_oe)
                smem[paddr] <= pdata;
            pend <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
        int fz = 0, we_lo = 0, oe_lo = 0;
        bit got = 0;
        int idx = int'((a - 32'd1024) >> 2);
        logic [31:0] e;
        mem_w_en = w; mem_r_en = r; addr = a; st_val = d;
        if (w) ref_mem[idx] = d;
        exp_q.push_back(w ? last_rd : ref_mem[idx]);
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                e = exp_q.pop_front();
                check(w ? "store_rd_hold" : "load_rd", rd_data, e);
                last_rd = e;
            end else begin
                if (freeze) fz++;
                if (!sram_we_n) we_lo++;
                if (!sram_oe_n) oe_lo++;
            end
        end
        check("ready_seen", 32'(got), 32'd1);
        check("freeze_len", fz, 5);
        check("we_low_cycles", we_lo, w ? 2 : 0);
        check("oe_low_cycles", oe_lo, w ? 0 : 4);
        @(posedge clk); #1;
        mem_w_en = 0; mem_r_en = 0;
    endtask

    initial begin
        bit hit = 0;
        for (int i = 0; i < 64; i++) smem[i] = 16'h0000;
        // 1: reset with a pending store request
        rst = 0; mem_w_en = 1; addr = 32'd1024; st_val = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we_n", sram_we_n, 1);
        check("rst_oe_n", sram_oe_n, 1);
        check("rst_dq_oe", sram_dq_oe, 0);
        check("rst_freeze", freeze, 0);
        check("rst_ready", ready, 0);
        check("rst_rd_data", rd_data, 0);
        mem_w_en = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        // 2: store
        access(1, 0, 32'd1028, 32'hDEADBEEF);
        check("st_hw2", smem[2], 16'hBEEF);
        check("st_hw3", smem[3], 16'hDEAD);
        // 3: load back
        access(0, 1, 32'd1028, 32'h0);
        check("ld_hw2_unchanged", smem[2], 16'hBEEF);
        check("ld_hw3_unchanged", smem[3], 16'hDEAD);
        // 4: back-to-back store then load
        access(1, 0, 32'd1024, 32'h11112222);
        access(0, 1, 32'd1024, 32'h0);
        check("b2b_hw0", smem[0], 16'h2222);
        check("b2b_hw1", smem[1], 16'h1111);
        // 5: reset during HI phase of a store
        smem[7] = 16'h5555;
        @(posedge clk); #1;
        mem_w_en = 1; addr = 32'd1036; st_val = 32'h1234CDEF;
        for (int i = 0; i < 20 && !hit; i++) begin
            @(negedge clk);
            if (sram_addr[0] && !sram_we_n) hit = 1;
        end
        check("hi_phase_seen", 32'(hit), 32'd1);
        rst = 0; mem_w_en = 0;
        @(negedge clk);
        check("abort_we_n", sram_we_n, 1);
        check("abort_dq_oe", sram_dq_oe, 0);
        check("abort_freeze", freeze, 0);
        check("abort_ready", ready, 0);
        rst = 1;
        repeat (3) @(negedge clk);
        check("abort_freeze_idle", freeze, 0);
        check("abort_hw6", smem[6], 16'hCDEF);
        check("abort_hw7", smem[7], 16'h5555);
        last_rd = '0;
        @(posedge clk); #1;
        // 6: read and write together, write wins
        access(1, 1, 32'd1032, 32'h0000ABCD);
        check("both_hw4", smem[4], 16'hABCD);
        check("both_hw5", smem[5], 16'h0000);
        access(0, 1, 32'd1032, 32'h0);
        access(0, 1, 32'd1028, 32'h0);
        check("sb_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
